plat_spawner: RTL and testbench

PLAT_SPAWNER -- requirements
Module: plat_spawner

---
 rtl/doodle_pkg.sv | 37 +++
 rtl/lfsr16.sv | 25 ++
 rtl/plat_spawner.sv | 182 ++++++++++++++++++
 tb/tb_plat_spawner.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared definitions for the platform spawner.
// Holds the parameter defaults, the controller state encoding, the LFSR
// feedback mask and a helper that computes the per-frame scroll amount.
package doodle_pkg;

  localparam int          NUM_PLAT_DEF    = 15;
  localparam int          SCROLL_LINE_DEF = 160;
  localparam int          MAX_SCROLL_DEF  = 8;
  localparam int          SCREEN_H_DEF    = 480;
  localparam logic [15:0] LFSR_SEED_DEF   = 16'hACE1;

  // Galois feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SCROLL,
    ST_DONE
  } state_e;

  // Pixels to scroll this frame: distance the doodle sits above the scroll
  // line, clamped to max_s; zero when the doodle is at or below the line.
  function automatic logic [3:0] calc_amt(input logic [9:0] doodle_y,
                                          input int line, input int max_s);
    int diff;
    diff = line - int'(doodle_y);
    if (diff <= 0)
      return 4'd0;
    else if (diff > max_s)
      return 4'(max_s);
    else
      return 4'(diff);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, right-shifting, feedback mask LFSR_MASK.
// Ports:
//   Clk     - system clock
//   Reset_n - asynchronous active-low reset, loads SEED
//   en      - advance one step when high
//   q       - current LFSR state (never zero for a non-zero seed)
module lfsr16
  import doodle_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      q <= SEED;
    else if (en)
      q <= q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  end

endmodule

// File: rtl/plat_spawner.sv
// Platform table for the doodle game.
// Keeps NUM_PLAT platform slots (left-edge X, top Y). On a layout request
// the slots are rewritten to an evenly spaced column with random X; on each
// VGA frame the whole table scrolls down by up to MAX_SCROLL pixels while
// the doodle is above SCROLL_LINE, recycling slots that fall off the bottom.
// Ports:
//   Clk, Reset_n - system clock, asynchronous active-low reset
//   frame_clk    - VGA vsync, asynchronous, synchronized internally
//   loadplat     - level request for a fresh layout
//   DoodleY      - doodle top Y
//   platX/platY  - per-slot platform position
//   scroll_amt   - pixels scrolled by the last completed update
//   height       - cumulative scrolled pixels, saturating
//   busy         - low only while idle
//   upd_done     - one-cycle pulse when an update or load completes
module plat_spawner
  import doodle_pkg::*;
#(
  parameter int          NUM_PLAT    = NUM_PLAT_DEF,
  parameter int          SCROLL_LINE = SCROLL_LINE_DEF,
  parameter int          MAX_SCROLL  = MAX_SCROLL_DEF,
  parameter int          SCREEN_H    = SCREEN_H_DEF,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_clk,
  input  logic                     loadplat,
  input  logic [9:0]               DoodleY,
  output logic [NUM_PLAT-1:0][9:0] platX,
  output logic [NUM_PLAT-1:0][9:0] platY,
  output logic [3:0]               scroll_amt,
  output logic [15:0]              height,
  output logic                     busy,
  output logic                     upd_done
);

  localparam int IDX_W = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAT - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       amt_q;
  logic             load_op_q;
  logic [3:0]       scroll_amt_q;
  logic [15:0]      height_q;
  logic [15:0]      height_d;
  logic [16:0]      height_sum;
  logic             busy_q;
  logic             upd_done_q;
  logic [2:0]       sync_q;
  logic             frame_tick;
  logic             sweep;
  logic [15:0]      lfsr_q;
  logic [9:0]       new_x;
  logic             lfsr_unused;

  // sync_q[1:0] is the two-flop synchronizer; sync_q[2] only serves edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      sync_q <= 3'b000;
    else
      sync_q <= {sync_q[1:0], frame_clk};
  end

  assign frame_tick = sync_q[1] & ~sync_q[2];

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .en     (1'b1),
    .q      (lfsr_q)
  );

  // 9 random bits offset by 32 keeps every X inside 32..543.
  assign new_x       = {1'b0, lfsr_q[8:0]} + 10'd32;
  assign lfsr_unused = ^lfsr_q[15:9];

  assign sweep      = (state_q == ST_LOAD) || (state_q == ST_SCROLL);
  assign height_sum = {1'b0, height_q} + {13'd0, amt_q};
  assign height_d   = height_sum[16] ? 16'hFFFF : height_sum[15:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      amt_q        <= 4'd0;
      load_op_q    <= 1'b0;
      scroll_amt_q <= 4'd0;
      height_q     <= 16'd0;
      busy_q       <= 1'b1;
      upd_done_q   <= 1'b0;
    end else begin
      upd_done_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          state_q   <= ST_LOAD;
          idx_q     <= '0;
          amt_q     <= 4'd0;
          load_op_q <= 1'b1;
          height_q  <= 16'd0;
          busy_q    <= 1'b1;
        end
        ST_IDLE: begin
          if (loadplat) begin
            state_q   <= ST_LOAD;
            idx_q     <= '0;
            amt_q     <= 4'd0;
            load_op_q <= 1'b1;
            height_q  <= 16'd0;
            busy_q    <= 1'b1;
          end else if (frame_tick) begin
            state_q   <= ST_SCROLL;
            idx_q     <= '0;
            amt_q     <= calc_amt(DoodleY, SCROLL_LINE, MAX_SCROLL);
            load_op_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_LOAD, ST_SCROLL: begin
          if (idx_q == LAST_IDX)
            state_q <= ST_DONE;
          else
            idx_q <= idx_q + 1'b1;
        end
        ST_DONE: begin
          upd_done_q   <= 1'b1;
          scroll_amt_q <= amt_q;
          if (!load_op_q)
            height_q <= height_d;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_INIT;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // One register pair per slot; a slot is written only in the cycle the
  // sweep index points at it.
  for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_slot
    logic [9:0] x_q;
    logic [9:0] y_q;
    logic [9:0] y_sum;
    logic       sel;

    assign sel   = sweep && (idx_q == IDX_W'(gi));
    assign y_sum = y_q + {6'd0, amt_q};

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        x_q <= 10'd0;
        y_q <= 10'd0;
      end else if (sel) begin
        if (state_q == ST_LOAD) begin
          y_q <= 10'(gi * 32);
          x_q <= new_x;
        end else if (y_sum >= 10'(SCREEN_H)) begin
          // Fell off the bottom: re-enter at the top with a fresh X.
          y_q <= y_sum - 10'(SCREEN_H);
          x_q <= new_x;
        end else begin
          y_q <= y_sum;
        end
      end
    end

    assign platX[gi] = x_q;
    assign platY[gi] = y_q;
  end

  assign scroll_amt = scroll_amt_q;
  assign height     = height_q;
  assign busy       = busy_q;
  assign upd_done   = upd_done_q;

endmodule

// File: tb/tb_plat_spawner.sv
// Directed bench for plat_spawner: a 15-slot instance for layout, scroll,
// wrap, ignored ticks, reload and mid-sweep reset, plus a 1-slot instance
// that runs thousands of fast frames to reach height saturation.
module tb_plat_spawner;

  localparam int NP = 15;

  logic              clk;
  logic              rst_n;
  logic              frame_clk;
  logic              loadplat;
  logic [9:0]        doodle_y;
  logic [NP-1:0][9:0] plat_x;
  logic [NP-1:0][9:0] plat_y;
  logic [3:0]        scroll_amt;
  logic [15:0]       height;
  logic              busy;
  logic              upd_done;

  logic              b_rst_n;
  logic              b_frame_clk;
  logic [0:0][9:0]   b_plat_x;
  logic [0:0][9:0]   b_plat_y;
  logic [3:0]        b_scroll_amt;
  logic [15:0]       b_height;
  logic              b_busy;
  logic              b_upd_done;

  int total = 0;
  int bad   = 0;

  plat_spawner dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .frame_clk (frame_clk),
    .loadplat  (loadplat),
    .DoodleY   (doodle_y),
    .platX     (plat_x),
    .platY     (plat_y),
    .scroll_amt(scroll_amt),
    .height    (height),
    .busy      (busy),
    .upd_done  (upd_done)
  );

  plat_spawner #(.NUM_PLAT(1)) dut_sat (
    .Clk       (clk),
    .Reset_n   (b_rst_n),
    .frame_clk (b_frame_clk),
    .loadplat  (1'b0),
    .DoodleY   (10'd0),
    .platX     (b_plat_x),
    .platY     (b_plat_y),
    .scroll_amt(b_scroll_amt),
    .height    (b_height),
    .busy      (b_busy),
    .upd_done  (b_upd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one frame edge (optionally a second edge mid-sweep) and watch
  // busy/upd_done for a fixed 40-cycle window.
  task automatic run_frame(input logic [9:0] dy, input bit dbl,
                           output int busy_n, output int upd_n);
    busy_n   = 0;
    upd_n    = 0;
    doodle_y = dy;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      frame_clk = (k < 3) || (dbl && k >= 6 && k < 9);
      busy_n += int'(busy);
      upd_n  += int'(upd_done);
    end
    frame_clk = 1'b0;
  endtask

  task automatic check_table(input string tag, input int exp_y[NP]);
    for (int i = 0; i < NP; i++) begin
      chk_val($sformatf("%s_y%0d", tag, i), 32'(plat_y[i]), 32'(exp_y[i]));
      chk_val($sformatf("%s_xrng%0d", tag, i),
              32'(plat_x[i] >= 10'd32 && plat_x[i] <= 10'd543), 32'd1);
    end
  endtask

  // Frame table: DoodleY, hand-computed scroll amount, double edge, expected height.
  logic [9:0] f_dy   [7] = '{10'd100, 10'd200, 10'd160, 10'd100, 10'd152, 10'd154, 10'd155};
  int         f_amt  [7] = '{8, 0, 0, 8, 8, 6, 5};
  bit         f_dbl  [7] = '{0, 0, 0, 1, 0, 0, 0};
  int         f_hgt  [7] = '{8, 8, 8, 16, 24, 30, 35};

  initial begin
    int exp_y[NP];
    int n;
    int busy_n;
    int upd_n;
    bit seen;

    rst_n       = 1'b0;
    b_rst_n     = 1'b0;
    frame_clk   = 1'b0;
    b_frame_clk = 1'b0;
    loadplat    = 1'b0;
    doodle_y    = 10'd300;

    repeat (3) @(negedge clk);
    #1;
    chk_val("rst_busy", 32'(busy), 32'd1);
    chk_val("rst_upd", 32'(upd_done), 32'd0);
    chk_val("rst_height", 32'(height), 32'd0);
    chk_val("rst_py", 32'(|plat_y), 32'd0);
    chk_val("rst_px", 32'(|plat_x), 32'd0);
    $display("reset: busy=%0d height=%0d", busy, height);

    // Initial layout: upd_done should be seen right after the 17th edge.
    #1;
    rst_n   = 1'b1;
    b_rst_n = 1'b1;
    n    = 0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (upd_done) seen = 1'b1;
    end
    chk_val("load_seen", 32'(seen), 32'd1);
    chk_val("load_latency", 32'(n), 32'd17);
    for (int i = 0; i < NP; i++) exp_y[i] = i * 32;
    check_table("load", exp_y);
    chk_val("load_height", 32'(height), 32'd0);
    chk_val("load_amt", 32'(scroll_amt), 32'd0);
    chk_val("load_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk_val("load_upd_width", 32'(upd_done), 32'd0);
    $display("load: edges=%0d platY[14]=%0d", n, plat_y[14]);

    // Scroll frames.
    for (int f = 0; f < 7; f++) begin
      run_frame(f_dy[f], f_dbl[f], busy_n, upd_n);
      for (int i = 0; i < NP; i++) begin
        exp_y[i] = exp_y[i] + f_amt[f];
        if (exp_y[i] >= 480) exp_y[i] = exp_y[i] - 480;
      end
      chk_val($sformatf("f%0d_busy", f), 32'(busy_n), 32'd16);
      chk_val($sformatf("f%0d_upd", f), 32'(upd_n), 32'd1);
      chk_val($sformatf("f%0d_amt", f), 32'(scroll_amt), 32'(f_amt[f]));
      chk_val($sformatf("f%0d_height", f), 32'(height), 32'(f_hgt[f]));
      check_table($sformatf("f%0d", f), exp_y);
      if (f == 5) chk_val("pre_wrap_y14", 32'(plat_y[14]), 32'd478);
      if (f == 6) begin
        chk_val("wrap_y14", 32'(plat_y[14]), 32'd3);
        chk_val("wrap_y13", 32'(plat_y[13]), 32'd451);
      end
      $display("frame %0d: dy=%0d amt=%0d height=%0d busy_cycles=%0d upd=%0d",
               f, f_dy[f], scroll_amt, height, busy_n, upd_n);
    end

    // Reload via loadplat clears height and restores the layout.
    @(negedge clk);
    loadplat = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    loadplat = 1'b0;
    chk_val("reload_start", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (upd_done) seen = 1'b1;
    end
    chk_val("reload_done", 32'(seen), 32'd1);
    for (int i = 0; i < NP; i++) exp_y[i] = i * 32;
    check_table("reload", exp_y);
    chk_val("reload_height", 32'(height), 32'd0);
    chk_val("reload_amt", 32'(scroll_amt), 32'd0);
    $display("reload: height=%0d platY[14]=%0d", height, plat_y[14]);

    // Reset in the middle of a scroll sweep.
    doodle_y = 10'd100;
    @(negedge clk);
    frame_clk = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk_val("midrst_started", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    frame_clk = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("midrst_py", 32'(|plat_y), 32'd0);
    chk_val("midrst_px", 32'(|plat_x), 32'd0);
    chk_val("midrst_amt", 32'(scroll_amt), 32'd0);
    chk_val("midrst_height", 32'(height), 32'd0);
    chk_val("midrst_busy", 32'(busy), 32'd1);
    chk_val("midrst_upd", 32'(upd_done), 32'd0);
    $display("mid-sweep reset: busy=%0d height=%0d", busy, height);

    // Saturation on the 1-slot instance: 8 pixels per frame, one frame every 4 cycles.
    for (int p = 0; p < 8191; p++) begin
      @(negedge clk);
      b_frame_clk = 1'b1;
      @(negedge clk);
      @(negedge clk);
      b_frame_clk = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk_val("sat_pre", 32'(b_height), 32'hFFF8);
    chk_val("sat_amt", 32'(b_scroll_amt), 32'd8);
    $display("saturation: frames=8191 height=%0h", b_height);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      b_frame_clk = 1'b1;
      repeat (3) @(negedge clk);
      b_frame_clk = 1'b0;
      repeat (8) @(negedge clk);
      chk_val($sformatf("sat_hold%0d", p), 32'(b_height), 32'hFFFF);
      $display("saturation: extra frame %0d height=%0h", p, b_height);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
